// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate-extension unit with valid/ready
// handshake and an output FIFO of DEPTH entries.
//
// Ports:
//   clk, rst_n          rising-edge clock, async active-low reset
//   in_valid/in_ready   input handshake (in_ready = FIFO not full)
//   in_imm[IN_W]        raw immediate field
//   in_mode[2]          00 sext, 01 zext, 10 sext<<SHIFT, 11 upper-place
//   out_valid/out_ready output handshake (out_valid = FIFO not empty)
//   out_data[OUT_W]     extended result at FIFO head
//   out_ovf             mode-10 result not representable in OUT_W signed
//   out_mode[2]         mode the head result was produced with
module imm_extend_pipe #(
  parameter int IN_W  = 13,
  parameter int OUT_W = 32,
  parameter int SHIFT = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic [1:0]       out_mode
);
  localparam int FW = IN_W + SHIFT;              // full-precision shifted width
  localparam int WW = (FW > OUT_W) ? FW : OUT_W; // working width for the shift
  localparam int EW = OUT_W + 3;                 // {mode, ovf, data}
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // ---------------- conversion (combinational) ----------------
  logic [WW-1:0]    sx_w, shl_w;
  logic             shl_ovf;
  logic [OUT_W-1:0] cv_data;
  logic             cv_ovf;

  assign sx_w  = {{(WW-IN_W){in_imm[IN_W-1]}}, in_imm};
  assign shl_w = sx_w << SHIFT;

  // Only when the shifted value is wider than OUT_W can it overflow: the
  // bits from FW-1 down to the new sign bit OUT_W-1 must all agree.
  generate
    if (FW > OUT_W) begin : g_ovf
      logic [FW-OUT_W:0] top;
      assign top     = shl_w[FW-1:OUT_W-1];
      assign shl_ovf = !((&top) || !(|top));
    end else begin : g_novf
      assign shl_ovf = 1'b0;
    end
  endgenerate

  always_comb begin
    cv_data = sx_w[OUT_W-1:0];
    cv_ovf  = 1'b0;
    case (in_mode)
      2'b00: cv_data = sx_w[OUT_W-1:0];
      2'b01: cv_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'b10: begin
        cv_data = shl_w[OUT_W-1:0];
        cv_ovf  = shl_ovf;
      end
      default: cv_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
    endcase
  end

  // ---------------- output FIFO ----------------
  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic [EW-1:0] last_q;   // last popped entry, shown while empty
  logic          push, pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {in_mode, cv_ovf, cv_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop) begin
        rptr   <= nxt(rptr);
        last_q <= mem[rptr];
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head comes straight from storage, so a result is visible right after
  // the accepting edge; when empty the last popped entry is held instead.
  assign {out_mode, out_ovf, out_data} = out_valid ? mem[rptr] : last_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: default instance (13->32, DEPTH=2)
// and a 31-bit-input instance for mode-10 overflow.
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, out_ovf;
  logic [12:0] in_imm;
  logic [1:0]  in_mode, out_mode;
  logic [31:0] out_data;

  logic        in2_valid, in2_ready, out2_valid, out2_ready, out2_ovf;
  logic [30:0] in2_imm;
  logic [1:0]  in2_mode, out2_mode;
  logic [31:0] out2_data;

  imm_extend_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
    .out_mode(out_mode));

  imm_extend_pipe #(.IN_W(31), .OUT_W(32), .SHIFT(2), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in2_valid), .in_ready(in2_ready),
    .in_imm(in2_imm), .in_mode(in2_mode), .out_valid(out2_valid),
    .out_ready(out2_ready), .out_data(out2_data), .out_ovf(out2_ovf),
    .out_mode(out2_mode));

  typedef struct packed {
    logic [31:0] d;
    logic        o;
    logic [1:0]  m;
  } exp_t;

  exp_t q1[$], q2[$];
  exp_t e1, e2;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: interpret the immediate as a signed integer and do plain
  // arithmetic; overflow is "outside the 32-bit signed range".
  function automatic exp_t model(input int w, input int sh, input longint imm,
                                 input logic [1:0] mode);
    longint v, r, one;
    exp_t e;
    one = 1;
    v = (imm >= (one << (w-1))) ? imm - (one << w) : imm;
    e.o = 1'b0;
    e.m = mode;
    case (mode)
      2'd0: r = v;
      2'd1: r = imm;
      2'd2: begin
        r = v * (one << sh);
        e.o = (r < -(one << 31)) || (r > (one << 31) - 1);
      end
      default: r = imm * (one << (32 - w));
    endcase
    e.d = r[31:0];
    return e;
  endfunction

  // Monitors: pop expected on every output handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      exp_t e;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon1 extra output: got %0h expected none", out_data);
      end else begin
        e = q1.pop_front();
        chk("mon1 data", out_data, e.d);
        chk("mon1 ovf", out_ovf, e.o);
        chk("mon1 mode", out_mode, e.m);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out2_valid && out2_ready) begin
      exp_t e;
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL mon2 extra output: got %0h expected none", out2_data);
      end else begin
        e = q2.pop_front();
        chk("mon2 data", out2_data, e.d);
        chk("mon2 ovf", out2_ovf, e.o);
        chk("mon2 mode", out2_mode, e.m);
      end
    end
  end

  // One cycle: record accepted inputs at the negedge, then move to #1 after
  // the next rising edge.
  task automatic step();
    @(negedge clk);
    if (rst_n && in_valid && in_ready) q1.push_back(e1);
    if (rst_n && in2_valid && in2_ready) q2.push_back(e2);
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic [12:0] imm, input logic [1:0] mode, input exp_t e);
    in_valid = 1'b1; in_imm = imm; in_mode = mode; e1 = e;
  endtask

  task automatic drive2(input logic [30:0] imm, input logic [1:0] mode, input exp_t e);
    in2_valid = 1'b1; in2_imm = imm; in2_mode = mode; e2 = e;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [12:0] d_imm [6];
  logic [1:0]  d_mode[6];
  exp_t        d_exp [6];
  exp_t        ea, eb, ec;

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_imm = '0; in_mode = '0; out_ready = 0;
    in2_valid = 0; in2_imm = '0; in2_mode = '0; out2_ready = 1;
    e1 = '0; e2 = '0;
    #12;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_ovf", out_ovf, 0);
    chk("reset out_mode", out_mode, 0);
    rst_n = 1'b1;
    #1;
    chk("reset in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors with known results.
    d_imm[0] = 13'h000A; d_mode[0] = 2'b00; d_exp[0] = '{32'h0000000A, 1'b0, 2'b00};
    d_imm[1] = 13'h1FE8; d_mode[1] = 2'b00; d_exp[1] = '{32'hFFFFFFE8, 1'b0, 2'b00};
    d_imm[2] = 13'h1FE8; d_mode[2] = 2'b01; d_exp[2] = '{32'h00001FE8, 1'b0, 2'b01};
    d_imm[3] = 13'h0001; d_mode[3] = 2'b11; d_exp[3] = '{32'h00080000, 1'b0, 2'b11};
    d_imm[4] = 13'h1FFF; d_mode[4] = 2'b11; d_exp[4] = '{32'hFFF80000, 1'b0, 2'b11};
    d_imm[5] = 13'h1B2E; d_mode[5] = 2'b10; d_exp[5] = '{32'hFFFFECB8, 1'b0, 2'b10};
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      drive1(d_imm[i], d_mode[i], d_exp[i]);
      step();
      in_valid = 0;
      chk("latency out_valid", out_valid, 1);
      chk("latency out_data", out_data, d_exp[i].d);
      step();
    end

    // 31-bit instance, mode 10 overflow boundary.
    drive2(31'h20000000, 2'b10, '{32'h80000000, 1'b1, 2'b10});
    step();
    drive2(31'h7FFFFFFF, 2'b10, '{32'hFFFFFFFC, 1'b0, 2'b10});
    step();
    in2_valid = 0;
    step(); step();

    // Backpressure with a full FIFO.
    out_ready = 0;
    ea = model(13, 2, 64'h0123, 2'b00);
    eb = model(13, 2, 64'h1ABC, 2'b10);
    ec = model(13, 2, 64'h0F0F, 2'b11);
    drive1(13'h0123, 2'b00, ea); step();
    chk("bp in_ready after A", in_ready, 1);
    drive1(13'h1ABC, 2'b10, eb); step();
    chk("bp in_ready full", in_ready, 0);
    drive1(13'h0F0F, 2'b11, ec); step();
    chk("bp in_ready held", in_ready, 0);
    chk("bp head stable", out_data, ea.d);
    out_ready = 1;
    step();   // A pops; C still refused since FIFO was full
    chk("bp in_ready return", in_ready, 1);
    step();   // C accepted, B pops
    in_valid = 0;
    step(); step();
    chk("bp drained", q1.size(), 0);

    // Steady stream: one in, one out each cycle.
    for (int i = 0; i < 8; i++) begin
      drive1(13'($urandom), 2'($urandom), '0);
      e1 = model(13, 2, longint'(in_imm), in_mode);
      step();
      chk("stream out_valid", out_valid, 1);
      chk("stream in_ready", in_ready, 1);
    end
    in_valid = 0;
    step(); step();

    // Reset in the middle of operation.
    out_ready = 0;
    drive1(13'h0055, 2'b01, model(13, 2, 64'h55, 2'b01)); step();
    drive1(13'h0066, 2'b00, model(13, 2, 64'h66, 2'b00)); step();
    in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset out_valid", out_valid, 0);
    chk("midreset out_data", out_data, 0);
    q1.delete(); q2.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    #1;
    chk("postreset in_ready", in_ready, 1);
    chk("postreset out_valid", out_valid, 0);
    @(posedge clk); #1;
    out_ready = 1;
    drive1(13'h1234, 2'b00, model(13, 2, 64'h1234, 2'b00)); step();
    in_valid = 0;
    step(); step();
    chk("postreset only new", q1.size(), 0);

    // Randomised traffic on both instances.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      in_imm    = 13'($urandom);
      in_mode   = 2'($urandom);
      e1        = model(13, 2, longint'(in_imm), in_mode);
      out_ready = ($urandom % 3) != 0;
      in2_valid = ($urandom % 4) != 0;
      in2_imm   = 31'($urandom);
      in2_mode  = 2'($urandom);
      e2        = model(31, 2, longint'(in2_imm), in2_mode);
      out2_ready = ($urandom % 3) != 0;
      step();
    end
    in_valid = 0; in2_valid = 0; out_ready = 1; out2_ready = 1;
    repeat (6) step();
    chk("random drained q1", q1.size(), 0);
    chk("random drained q2", q2.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
